// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle position controller and the drawing
// stage that consumes its xpos/ypos.
//   - state_t     : controller FSM states
//   - SCREEN_W/H  : visible area in pixels
//   - RECT_WIDTH/HEIGHT : rectangle size, must match the drawing stage
//   - XMAX/FLOOR  : largest legal left edge / top edge of the rectangle
package rect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FALL   = 2'd1,
        BOUNCE = 2'd2,
        LANDED = 2'd3
    } state_t;

    localparam int SCREEN_W    = 800;
    localparam int SCREEN_H    = 600;
    localparam int RECT_WIDTH  = 48;
    localparam int RECT_HEIGHT = 64;

    localparam int XMAX  = SCREEN_W - RECT_WIDTH;   // 752
    localparam int FLOOR = SCREEN_H - RECT_HEIGHT;  // 536

endpackage

// File: rtl/rect_pos_ctl_edge_rise.sv
// 1-bit rising-edge detector.
//   pclk : clock
//   rst  : synchronous active-high reset; history reg loads RST_VAL
//   din  : level input, already synchronous to pclk
//   rise : high for one cycle when din goes 0 -> 1
// Resetting the history to 1 means a level that is already high at reset
// release does not count as an edge.
module edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic pclk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_d_q;
    logic din_d_d;

    always_comb begin
        din_d_d = din;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            din_d_q <= RST_VAL;
        end else begin
            din_d_q <= din_d_d;
        end
    end

    assign rise = din & ~din_d_q;

endmodule

// File: rtl/rect_pos_ctl.sv
// Rectangle position controller.
// Follows the mouse (clamped to the screen) until a left click, then drops the
// rectangle under per-frame gravity with damped bounces on the screen floor.
// Motion advances once per frame on the rising edge of vblnk_in.
// Ports:
//   pclk       : pixel clock
//   rst        : synchronous active-high reset
//   vblnk_in   : vertical blank, rising edge = frame tick
//   mouse_left : left button level (synchronous to pclk)
//   mouse_xpos : mouse x, px (12 bits)
//   mouse_ypos : mouse y, px (12 bits)
//   xpos       : rectangle left edge, px, registered
//   ypos       : rectangle top edge, px, registered
//   moving     : high while falling or bouncing, registered
// Velocity and vertical position are kept with FRAC fractional bits; ypos is
// the integer part of the position accumulator.
module rect_pos_ctl
    import rect_pkg::*;
#(
    parameter int FRAC    = 4,
    parameter int GRAVITY = 4,
    parameter int VMAX    = 256,
    parameter int VMIN    = 16
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        moving
);

    localparam int AW = 12 + FRAC;

    localparam logic [11:0] XMAX_C    = 12'(XMAX);
    localparam logic [11:0] FLOOR_C   = 12'(FLOOR);
    localparam logic [11:0] GRAV_C    = 12'(GRAVITY);
    localparam logic [11:0] VMAX_C    = 12'(VMAX);
    localparam logic [11:0] VMIN_C    = 12'(VMIN);
    localparam logic [AW:0] FLOOR_FIX = (AW + 1)'(FLOOR) << FRAC;

    // Frame tick and click events
    logic tick;
    logic click;

    edge_rise #(.RST_VAL(1'b1)) u_tick_edge (
        .pclk (pclk),
        .rst  (rst),
        .din  (vblnk_in),
        .rise (tick)
    );

    edge_rise #(.RST_VAL(1'b1)) u_click_edge (
        .pclk (pclk),
        .rst  (rst),
        .din  (mouse_left),
        .rise (click)
    );

    state_t        state_q, state_d;
    logic [11:0]   vel_q, vel_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [11:0]   xpos_q, xpos_d;
    logic [11:0]   ypos_q, ypos_d;
    logic          moving_q, moving_d;

    // Datapath intermediates
    logic [11:0]   x_clamp;
    logic [11:0]   y_clamp;
    logic [11:0]   vel_inc;
    logic [11:0]   vel_fall;
    logic [11:0]   vel_rebound;
    logic [AW:0]   acc_sum;   // one bit wider so the floor compare never wraps
    logic [AW-1:0] acc_up;

    always_comb begin
        x_clamp     = (mouse_xpos > XMAX_C)  ? XMAX_C  : mouse_xpos;
        y_clamp     = (mouse_ypos > FLOOR_C) ? FLOOR_C : mouse_ypos;
        vel_inc     = vel_q + GRAV_C;
        vel_fall    = (vel_inc > VMAX_C) ? VMAX_C : vel_inc;
        vel_rebound = vel_fall - (vel_fall >> 2);
        acc_sum     = (AW + 1)'(acc_q) + (AW + 1)'(vel_fall);
        acc_up      = (acc_q >= AW'(vel_q)) ? (acc_q - AW'(vel_q)) : '0;
    end

    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        acc_d   = acc_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;

        unique case (state_q)
            IDLE: begin
                if (click) begin
                    // Freeze where the rectangle is now; a coincident tick
                    // produces no motion this frame.
                    state_d = FALL;
                    vel_d   = '0;
                end else begin
                    xpos_d = x_clamp;
                    ypos_d = y_clamp;
                    acc_d  = AW'(y_clamp) << FRAC;
                end
            end
            FALL: begin
                if (tick) begin
                    if (acc_sum >= FLOOR_FIX) begin
                        acc_d = FLOOR_FIX[AW-1:0];
                        if (vel_rebound < VMIN_C) begin
                            state_d = LANDED;
                            vel_d   = '0;
                        end else begin
                            state_d = BOUNCE;
                            vel_d   = vel_rebound;
                        end
                    end else begin
                        acc_d = acc_sum[AW-1:0];
                        vel_d = vel_fall;
                    end
                end
            end
            BOUNCE: begin
                if (tick) begin
                    acc_d = acc_up;
                    if (vel_q <= GRAV_C) begin
                        // Apex reached: start falling again from rest
                        state_d = FALL;
                        vel_d   = '0;
                    end else begin
                        vel_d = vel_q - GRAV_C;
                    end
                end
            end
            LANDED: begin
                if (click) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q == FALL || state_q == BOUNCE) begin
            ypos_d = acc_d[AW-1:FRAC];
        end

        moving_d = (state_d == FALL) || (state_d == BOUNCE);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= IDLE;
            vel_q    <= '0;
            acc_q    <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vel_q    <= vel_d;
            acc_q    <= acc_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            moving_q <= moving_d;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign moving = moving_q;

endmodule
